vga_timing_gen: RTL and testbench

//  Self-contained, parametrised VGA/SVGA raster timing generator. Owns horizontal and vertical

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_axis_timer.sv | 52 +++++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA raster timing generator: per-axis timing
// description, its total-length helper, and two standard display modes.
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  function automatic int unsigned axis_total(input vga_axis_t a);
    return a.active + a.front + a.sync + a.back;
  endfunction

  localparam vga_mode_t VGA_640x480_60 = '{
    h: '{active: 640, front: 16, sync: 96, back: 48},
    v: '{active: 480, front: 10, sync: 2,  back: 33}
  };

  localparam vga_mode_t SVGA_800x600_56 = '{
    h: '{active: 800, front: 24, sync: 72, back: 128},
    v: '{active: 600, front: 1,  sync: 2,  back: 22}
  };

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: wrapping position counter plus decodes of the position it
// will hold after this cycle's step, so the caller can register aligned outputs.
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter vga_axis_t AX  = SVGA_800x600_56.h,
  parameter logic      POL = 1'b1,
  parameter int        CW  = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_step,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_nxt,
  output logic          o_wrap,
  output logic          o_active,
  output logic          o_sync,
  output logic          o_sync_first
);

  localparam int unsigned TOTAL = axis_total(AX);
  localparam int unsigned SS    = AX.active + AX.front;
  localparam int unsigned SE    = SS + AX.sync;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  if (TOTAL > (64'd1 << CW)) begin : g_size_err
    $error("vga_axis_timer: axis total exceeds counter width");
  end

  logic [CW-1:0] r_cnt;
  logic          w_last;
  logic [CW-1:0] w_nxt;
  logic [31:0]   w_nxt32;

  assign w_last  = (r_cnt == LAST);
  assign o_wrap  = i_step & w_last;
  assign w_nxt   = !i_step ? r_cnt : (w_last ? '0 : r_cnt + 1'b1);
  assign w_nxt32 = 32'(w_nxt);

  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_nxt;
  end

  assign o_cnt        = r_cnt;
  assign o_nxt        = w_nxt;
  assign o_active     = (w_nxt32 < AX.active);
  // Sync decode already carries the polarity so the top just registers it.
  assign o_sync       = ((w_nxt32 >= SS) && (w_nxt32 < SE)) ? POL : ~POL;
  assign o_sync_first = (w_nxt32 == SS);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/SVGA raster timing generator: pixel divider, h/v axis timers, registered
// sync/blank/position/strobe outputs. Optional frame counter: VGA_FRAME_COUNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   WIDTH     = 800,
  parameter int   HFRONT    = 24,
  parameter int   HSYNC     = 72,
  parameter int   HBACK     = 128,
  parameter int   HEIGHT    = 600,
  parameter int   VFRONT    = 1,
  parameter int   VSYNC     = 2,
  parameter int   VBACK     = 22,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   PIX_DIV   = 1,
  parameter int   CW        = 11,
  parameter int   FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               hsync,
  output logic               vsync,
  output logic               hblank,
  output logic               vblank,
  output logic               blank,
  output logic [CW-1:0]      x_pos,
  output logic [CW-1:0]      y_pos,
  output logic               pix_stb,
  output logic               next_row,
  output logic               next_frame,
  output logic               vsync_pulse,
  output logic [FRAME_W-1:0] frame_count
);

  localparam vga_axis_t H_AX = '{active: WIDTH,  front: HFRONT, sync: HSYNC, back: HBACK};
  localparam vga_axis_t V_AX = '{active: HEIGHT, front: VFRONT, sync: VSYNC, back: VBACK};
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  if (PIX_DIV < 1) begin : g_div_err
    $error("vga_timing_gen: PIX_DIV must be at least 1");
  end

  logic          w_adv;
  logic [CW-1:0] w_h_cnt, w_h_nxt, w_v_cnt, w_v_nxt;
  logic          w_h_wrap, w_h_act, w_h_sync, w_h_sync_first;
  logic          w_v_wrap, w_v_act, w_v_sync, w_v_sync_first;
  logic          w_h_zero, w_frame_start;

  if (PIX_DIV > 1) begin : g_div
    logic [DW-1:0] r_div;
    assign w_adv = enable && (r_div == DW'(PIX_DIV - 1));
    always_ff @(posedge clk) begin
      if (reset)       r_div <= '0;
      else if (w_adv)  r_div <= '0;
      else if (enable) r_div <= r_div + 1'b1;
    end
  end else begin : g_nodiv
    assign w_adv = enable;
  end

  vga_axis_timer #(.AX(H_AX), .POL(HSYNC_POL), .CW(CW)) u_h (
    .clk(clk), .reset(reset), .i_step(w_adv),
    .o_cnt(w_h_cnt), .o_nxt(w_h_nxt), .o_wrap(w_h_wrap),
    .o_active(w_h_act), .o_sync(w_h_sync), .o_sync_first(w_h_sync_first)
  );

  vga_axis_timer #(.AX(V_AX), .POL(VSYNC_POL), .CW(CW)) u_v (
    .clk(clk), .reset(reset), .i_step(w_h_wrap),
    .o_cnt(w_v_cnt), .o_nxt(w_v_nxt), .o_wrap(w_v_wrap),
    .o_active(w_v_act), .o_sync(w_v_sync), .o_sync_first(w_v_sync_first)
  );

  assign w_h_zero      = (w_h_nxt == '0);
  assign w_frame_start = w_h_zero && (w_v_nxt == '0);

  // Strobes are gated by adv so they fall to 0 on any non-advancing cycle;
  // levels and positions only load on adv, so a pause freezes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      blank       <= 1'b1;
      x_pos       <= '0;
      y_pos       <= '0;
      pix_stb     <= 1'b0;
      next_row    <= 1'b0;
      next_frame  <= 1'b0;
      vsync_pulse <= 1'b0;
    end else begin
      pix_stb     <= w_adv;
      next_row    <= w_adv & w_h_zero;
      next_frame  <= w_adv & w_frame_start;
      vsync_pulse <= w_adv & w_h_zero & w_v_sync_first;
      if (w_adv) begin
        hsync  <= w_h_sync;
        vsync  <= w_v_sync;
        hblank <= ~w_h_act;
        vblank <= ~w_v_act;
        blank  <= ~(w_h_act & w_v_act);
        x_pos  <= (w_h_act & w_v_act) ? w_h_nxt : '0;
        y_pos  <= w_v_act ? w_v_nxt : '0;
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [FRAME_W-1:0] r_frame;
  always_ff @(posedge clk) begin
    if (reset)                      r_frame <= '0;
    else if (w_adv & w_frame_start) r_frame <= r_frame + 1'b1;
  end
  assign frame_count = r_frame;
`else
  assign frame_count = '0;
`endif

  logic w_unused;
  assign w_unused = ^{w_h_cnt, w_v_cnt, w_v_wrap, w_h_sync_first};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x8 raster: PIX_DIV=1 and PIX_DIV=3
// instances side by side, pause, mid-line reset and optional frame count.
module tb_vga_timing_gen;

  localparam int CW = 11;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic reset, en1, en3;
  always #5 clk = ~clk;

  logic d1_hs, d1_vs, d1_hb, d1_vb, d1_bl, d1_pix, d1_row, d1_frm, d1_vp;
  logic [CW-1:0] d1_x, d1_y;
  logic [FW-1:0] d1_fc;
  logic d3_hs, d3_vs, d3_hb, d3_vb, d3_bl, d3_pix, d3_row, d3_frm, d3_vp;
  logic [CW-1:0] d3_x, d3_y;
  logic [FW-1:0] d3_fc;

  vga_timing_gen #(.WIDTH(8), .HFRONT(2), .HSYNC(3), .HBACK(3),
                   .HEIGHT(4), .VFRONT(1), .VSYNC(2), .VBACK(1),
                   .PIX_DIV(1), .CW(CW), .FRAME_W(FW)) dut1 (
    .clk(clk), .reset(reset), .enable(en1),
    .hsync(d1_hs), .vsync(d1_vs), .hblank(d1_hb), .vblank(d1_vb), .blank(d1_bl),
    .x_pos(d1_x), .y_pos(d1_y), .pix_stb(d1_pix), .next_row(d1_row),
    .next_frame(d1_frm), .vsync_pulse(d1_vp), .frame_count(d1_fc)
  );

  vga_timing_gen #(.WIDTH(8), .HFRONT(2), .HSYNC(3), .HBACK(3),
                   .HEIGHT(4), .VFRONT(1), .VSYNC(2), .VBACK(1),
                   .PIX_DIV(3), .CW(CW), .FRAME_W(FW)) dut3 (
    .clk(clk), .reset(reset), .enable(en3),
    .hsync(d3_hs), .vsync(d3_vs), .hblank(d3_hb), .vblank(d3_vb), .blank(d3_bl),
    .x_pos(d3_x), .y_pos(d3_y), .pix_stb(d3_pix), .next_row(d3_row),
    .next_frame(d3_frm), .vsync_pulse(d3_vp), .frame_count(d3_fc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset1(input string pfx);
    chk({pfx, "_hsync"}, d1_hs, 0);
    chk({pfx, "_vsync"}, d1_vs, 0);
    chk({pfx, "_hblank"}, d1_hb, 1);
    chk({pfx, "_vblank"}, d1_vb, 1);
    chk({pfx, "_blank"}, d1_bl, 1);
    chk({pfx, "_x"}, d1_x, 0);
    chk({pfx, "_y"}, d1_y, 0);
    chk({pfx, "_strobes"}, {d1_pix, d1_row, d1_frm, d1_vp}, 0);
    chk({pfx, "_fc"}, d1_fc, 0);
  endtask

  initial begin
    int h, v, m, h3, v3;
    int last_row, last_frm, last_row3;
    reset = 1'b1; en1 = 1'b1; en3 = 1'b1;
    last_row = -1; last_frm = -1; last_row3 = -1;

    repeat (3) tick();
    chk_reset1("rst");
    chk("rst3_hsync", d3_hs, 0);
    chk("rst3_blank", d3_bl, 1);
    chk("rst3_strobes", {d3_pix, d3_row, d3_frm, d3_vp}, 0);

    // Five full frames on both instances; position after k edges is known in closed form.
    reset = 1'b0;
    for (int k = 1; k <= 640; k++) begin
      tick();
      h = k % 16; v = (k / 16) % 8;
      chk("hsync", d1_hs, (h >= 10 && h < 13));
      chk("vsync", d1_vs, (v >= 5 && v < 7));
      chk("hblank", d1_hb, (h >= 8));
      chk("vblank", d1_vb, (v >= 4));
      chk("blank", d1_bl, (h >= 8 || v >= 4));
      chk("x", d1_x, (h < 8 && v < 4) ? h : 0);
      chk("y", d1_y, (v < 4) ? v : 0);
      chk("pix", d1_pix, 1);
      chk("row", d1_row, (h == 0));
      chk("frame", d1_frm, (h == 0 && v == 0));
      chk("vpulse", d1_vp, (h == 0 && v == 5));
`ifdef VGA_FRAME_COUNT_EN
      chk("fc", d1_fc, (k / 128) % 4);
`else
      chk("fc", d1_fc, 0);
`endif
      if (d1_row) begin
        if (last_row >= 0) chk("row_period", k - last_row, 16);
        last_row = k;
      end
      if (d1_frm) begin
        if (last_frm >= 0) chk("frame_period", k - last_frm, 128);
        last_frm = k;
      end
      m = k / 3; h3 = m % 16; v3 = (m / 16) % 8;
      chk("pix3", d3_pix, (k % 3 == 0));
      chk("x3", d3_x, (h3 < 8 && v3 < 4) ? h3 : 0);
      chk("row3", d3_row, (k % 3 == 0) && (h3 == 0));
      if (d3_row) begin
        if (last_row3 >= 0) chk("row3_period", k - last_row3, 48);
        last_row3 = k;
      end
    end
`ifdef VGA_FRAME_COUNT_EN
    chk("fc_5frames", d1_fc, 1);
`endif

    // Pause at x=5 of line 0.
    repeat (5) tick();
    chk("pre_pause_x", d1_x, 5);
    en1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_x", d1_x, 5);
      chk("pause_lvls", {d1_hs, d1_vs, d1_hb, d1_vb, d1_bl}, 0);
      chk("pause_y", d1_y, 0);
      chk("pause_strobes", {d1_pix, d1_row, d1_frm, d1_vp}, 0);
    end
    en1 = 1'b1;
    tick();
    chk("resume_pix", d1_pix, 1);
    chk("resume_x", d1_x, 6);

    // Walk to h=9, v=2 then reset mid-line.
    repeat (35) tick();
    chk("mid_hblank", d1_hb, 1);
    chk("mid_x", d1_x, 0);
    chk("mid_y", d1_y, 2);
    reset = 1'b1;
    tick();
    chk_reset1("midrst");
    reset = 1'b0;
    tick();
    chk("post_rst_x", d1_x, 1);
    chk("post_rst_blank", d1_bl, 0);
    chk("post_rst_pix", d1_pix, 1);
    chk("post_rst_row", d1_row, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
